// File: rtl/sata_rx_prim_decode.sv
// SATA receive primitive decoder: classifies each rx dword, resolves CONTp
// suppression, flags bad/unknown K dwords and counts errors (saturating).
// Ports: clk, rst_n (async, active-low), phy_ready gates decode;
//   rxdata_in/rxcharisk_in raw dword; err_cnt_clr sync clear;
//   rx_prim one-hot (bit 1 never set), rx_data/rx_data_val data path,
//   rx_cont_active, err_unknown_prim/err_charisk pulses, err_cnt.
module sata_rx_prim_decode #(
  parameter int DATA_BYTE_WIDTH = 4,
  parameter int ERR_CNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     phy_ready,
  input  logic [31:0]              rxdata_in,
  input  logic [3:0]               rxcharisk_in,
  input  logic                     err_cnt_clr,
  output logic [17:0]              rx_prim,
  output logic [31:0]              rx_data,
  output logic                     rx_data_val,
  output logic                     rx_cont_active,
  output logic                     err_unknown_prim,
  output logic                     err_charisk,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  if (DATA_BYTE_WIDTH != 4) begin : g_bad_cfg
    $error("sata_rx_prim_decode: DATA_BYTE_WIDTH must be 4");
  end

  // index 0 is the rightmost entry
  localparam logic [17:0][31:0] TAB = {
    32'hF5F5957C, 32'h9595957C, 32'h7575957C,
    32'h1717B57C, 32'h3636B57C, 32'h5858B57C,
    32'h9595AA7C, 32'hD5D5AA7C, 32'hD5D5B57C,
    32'h3737B57C, 32'h5757B57C, 32'h5656B57C,
    32'h3535B57C, 32'h5555B57C, 32'h4A4A957C,
    32'hB5B5957C, 32'h9999AA7C, 32'h7B4A4ABC
  };

  logic [17:0] held_q, held_d;
  logic        cont_q, cont_d;
  logic [17:0] prim_d;
  logic [31:0] data_d;
  logic        val_d;
  logic        err_u_d;
  logic        err_k_d;
  logic [17:0] hit;
  logic        is_k, is_d;
  logic        is_align, is_cont, is_oth, is_unk;
  logic        is_junk, is_dat, is_bad;

  always_comb begin
    for (int i = 0; i < 18; i++)
      hit[i] = (rxdata_in == TAB[i]);
  end

  assign is_k     = (rxcharisk_in == 4'b0001);
  assign is_d     = (rxcharisk_in == 4'b0000);
  assign is_align = is_k & hit[0];
  assign is_cont  = is_k & hit[1];
  assign is_oth   = is_k & (|hit[17:2]);
  assign is_unk   = is_k & ~(|hit);
  assign is_junk  = is_d & cont_q;
  assign is_dat   = is_d & ~cont_q;
  assign is_bad   = ~is_k & ~is_d;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q <= '0;
      cont_q <= 1'b0;
    end else begin
      held_q <= held_d;
      cont_q <= cont_d;
    end
  end

  // next state
  always_comb begin
    held_d = held_q;
    cont_d = cont_q;
    if (!phy_ready) begin
      held_d = '0;
      cont_d = 1'b0;
    end else begin
      unique case (1'b1)
        is_align: ;
        is_cont:  cont_d = 1'b1;
        is_oth: begin
          held_d = hit;
          cont_d = 1'b0;
        end
        is_junk: ;
        is_dat:  held_d = '0;
        default: begin
          held_d = '0;
          cont_d = 1'b0;
        end
      endcase
    end
  end

  // output decode
  always_comb begin
    prim_d  = '0;
    data_d  = '0;
    val_d   = 1'b0;
    err_u_d = 1'b0;
    err_k_d = 1'b0;
    if (phy_ready) begin
      unique case (1'b1)
        is_align: prim_d = 18'h1;
        is_cont:  prim_d = held_q;
        is_oth:   prim_d = hit;
        is_junk:  prim_d = held_q;
        is_dat: begin
          val_d  = 1'b1;
          data_d = rxdata_in;
        end
        is_unk:  err_u_d = 1'b1;
        is_bad:  err_k_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prim          <= '0;
      rx_data          <= '0;
      rx_data_val      <= 1'b0;
      err_unknown_prim <= 1'b0;
      err_charisk      <= 1'b0;
    end else begin
      rx_prim          <= prim_d;
      rx_data          <= data_d;
      rx_data_val      <= val_d;
      err_unknown_prim <= err_u_d;
      err_charisk      <= err_k_d;
    end
  end

  assign rx_cont_active = cont_q;

  // clear wins over the count, but a same-cycle error still counts once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (err_cnt_clr)
      err_cnt <= (err_u_d | err_k_d) ? ERR_CNT_WIDTH'(1) : '0;
    else if ((err_u_d | err_k_d) && !(&err_cnt))
      err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_sata_rx_prim_decode.sv
// Directed bench for sata_rx_prim_decode.
// One task per scenario; inline comparisons and a final summary.
module tb_sata_rx_prim_decode;

  localparam logic [31:0] ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] CONT  = 32'h9999AA7C;
  localparam logic [31:0] SYNC  = 32'hB5B5957C;
  localparam logic [31:0] X_RDY = 32'h5757B57C;
  localparam logic [31:0] HOLD  = 32'hD5D5AA7C;
  localparam logic [31:0] R_IP  = 32'h5555B57C;
  localparam logic [31:0] JUNK  = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        phy_ready = 1'b0;
  logic [31:0] rxdata_in = '0;
  logic [3:0]  rxcharisk_in = '0;
  logic        err_cnt_clr = 1'b0;
  logic [17:0] rx_prim;
  logic [31:0] rx_data;
  logic        rx_data_val;
  logic        rx_cont_active;
  logic        err_unknown_prim;
  logic        err_charisk;
  logic [15:0] err_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sata_rx_prim_decode #(
    .DATA_BYTE_WIDTH(4),
    .ERR_CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .phy_ready(phy_ready),
    .rxdata_in(rxdata_in),
    .rxcharisk_in(rxcharisk_in),
    .err_cnt_clr(err_cnt_clr),
    .rx_prim(rx_prim),
    .rx_data(rx_data),
    .rx_data_val(rx_data_val),
    .rx_cont_active(rx_cont_active),
    .err_unknown_prim(err_unknown_prim),
    .err_charisk(err_charisk),
    .err_cnt(err_cnt)
  );

  task automatic drive(input logic [31:0] d, input logic [3:0] k);
    rxdata_in    = d;
    rxcharisk_in = k;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #13;
    checks++;
    if ({rx_prim, rx_data, rx_data_val, rx_cont_active,
         err_unknown_prim, err_charisk, err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset: prim=%h data=%h val=%b cont=%b eu=%b ek=%b cnt=%h want all 0",
               rx_prim, rx_data, rx_data_val, rx_cont_active,
               err_unknown_prim, err_charisk, err_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    phy_ready = 1'b1;
  endtask

  task automatic test_basic;
    logic [31:0] vd [4];
    logic [17:0] vp [4];
    vd = '{SYNC, SYNC, X_RDY, 32'h12345678};
    vp = '{18'h4, 18'h4, 18'h80, 18'h0};
    for (int i = 0; i < 4; i++) begin
      drive(vd[i], (i == 3) ? 4'b0000 : 4'b0001);
      checks++;
      if (rx_prim !== vp[i] || rx_data_val !== (i == 3) ||
          (i == 3 && rx_data !== 32'h12345678)) begin
        errors++;
        $display("FAIL basic[%0d]: prim=%h val=%b data=%h want prim=%h val=%b",
                 i, rx_prim, rx_data_val, rx_data, vp[i], i == 3);
      end
    end
  endtask

  task automatic test_cont_hold;
    logic [31:0] vd [8];
    logic [3:0]  vk [8];
    logic [17:0] vp [8];
    logic        vc [8];
    vd = '{HOLD, CONT, JUNK, JUNK, JUNK, ALIGN, JUNK, R_IP};
    vk = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1};
    vp = '{18'h400, 18'h400, 18'h400, 18'h400, 18'h400,
           18'h1, 18'h400, 18'h10};
    vc = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      drive(vd[i], vk[i]);
      checks++;
      if (rx_prim !== vp[i] || rx_cont_active !== vc[i] ||
          rx_data_val !== 1'b0) begin
        errors++;
        $display("FAIL cont_hold[%0d]: prim=%h cont=%b val=%b want prim=%h cont=%b val=0",
                 i, rx_prim, rx_cont_active, rx_data_val, vp[i], vc[i]);
      end
    end
  endtask

  task automatic test_orphan_cont;
    logic [31:0] vd [3];
    logic [3:0]  vk [3];
    vd = '{32'h11223344, CONT, JUNK};
    vk = '{4'h0, 4'h1, 4'h0};
    for (int i = 0; i < 3; i++) begin
      drive(vd[i], vk[i]);
      checks++;
      if (rx_prim !== 18'h0 || rx_data_val !== (i == 0) ||
          rx_cont_active !== (i != 0)) begin
        errors++;
        $display("FAIL orphan[%0d]: prim=%h val=%b cont=%b want prim=0 val=%b cont=%b",
                 i, rx_prim, rx_data_val, rx_cont_active, i == 0, i != 0);
      end
    end
  endtask

  task automatic test_errors;
    err_cnt_clr = 1'b1;
    drive(SYNC, 4'b0001);
    err_cnt_clr = 1'b0;
    checks++;
    if (err_cnt !== 16'h0 || rx_prim !== 18'h4) begin
      errors++;
      $display("FAIL clr: cnt=%h prim=%h want 0 / 4", err_cnt, rx_prim);
    end
    drive(32'h0000DEAD, 4'b0011);
    checks++;
    if (err_charisk !== 1'b1 || err_unknown_prim !== 1'b0 ||
        rx_prim !== 18'h0 || err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL charisk: ek=%b eu=%b prim=%h cnt=%h want 1/0/0/1",
               err_charisk, err_unknown_prim, rx_prim, err_cnt);
    end
    drive(32'h1234567C, 4'b0001);
    checks++;
    if (err_unknown_prim !== 1'b1 || err_charisk !== 1'b0 ||
        err_cnt !== 16'd2) begin
      errors++;
      $display("FAIL unknown: eu=%b ek=%b cnt=%h want 1/0/2",
               err_unknown_prim, err_charisk, err_cnt);
    end
    drive(SYNC, 4'b0001);
    checks++;
    if (err_unknown_prim !== 1'b0 || err_charisk !== 1'b0 ||
        err_cnt !== 16'd2) begin
      errors++;
      $display("FAIL err_end: eu=%b ek=%b cnt=%h want 0/0/2",
               err_unknown_prim, err_charisk, err_cnt);
    end
    for (int i = 0; i < 65535; i++)
      drive(32'h0, 4'b1111);
    checks++;
    if (err_cnt !== 16'hFFFF || err_charisk !== 1'b1) begin
      errors++;
      $display("FAIL saturate: cnt=%h ek=%b want ffff/1", err_cnt, err_charisk);
    end
    drive(32'h0, 4'b1000);
    checks++;
    if (err_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: cnt=%h want ffff", err_cnt);
    end
    err_cnt_clr = 1'b1;
    drive(32'h0, 4'b0110);
    err_cnt_clr = 1'b0;
    checks++;
    if (err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL clr_err: cnt=%h want 1", err_cnt);
    end
  endtask

  task automatic test_phy_drop;
    drive(HOLD, 4'b0001);
    drive(CONT, 4'b0001);
    drive(JUNK, 4'b0000);
    checks++;
    if (rx_cont_active !== 1'b1 || rx_prim !== 18'h400) begin
      errors++;
      $display("FAIL pre_drop: cont=%b prim=%h want 1/400",
               rx_cont_active, rx_prim);
    end
    phy_ready = 1'b0;
    drive(32'h0, 4'b1111);
    checks++;
    if (rx_prim !== '0 || rx_cont_active !== 1'b0 ||
        rx_data_val !== 1'b0 || err_charisk !== 1'b0 ||
        err_unknown_prim !== 1'b0 || err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL drop: prim=%h cont=%b val=%b ek=%b eu=%b cnt=%h want 0s cnt=1",
               rx_prim, rx_cont_active, rx_data_val, err_charisk,
               err_unknown_prim, err_cnt);
    end
    phy_ready = 1'b1;
    drive(JUNK, 4'b0000);
    checks++;
    if (rx_data_val !== 1'b1 || rx_data !== JUNK || rx_prim !== '0) begin
      errors++;
      $display("FAIL rise: val=%b data=%h prim=%h want 1/deadbeef/0",
               rx_data_val, rx_data, rx_prim);
    end
    phy_ready = 1'b0;
    err_cnt_clr = 1'b1;
    drive(JUNK, 4'b0000);
    err_cnt_clr = 1'b0;
    phy_ready = 1'b1;
    checks++;
    if (err_cnt !== 16'd0 || rx_data_val !== 1'b0) begin
      errors++;
      $display("FAIL drop_clr: cnt=%h val=%b want 0/0", err_cnt, rx_data_val);
    end
  endtask

  task automatic test_async_reset;
    drive(32'h0, 4'b0011);
    drive(HOLD, 4'b0001);
    drive(CONT, 4'b0001);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_prim, rx_data_val, rx_cont_active, err_charisk,
         err_unknown_prim, err_cnt} !== '0) begin
      errors++;
      $display("FAIL async_rst: prim=%h val=%b cont=%b cnt=%h want 0s",
               rx_prim, rx_data_val, rx_cont_active, err_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(JUNK, 4'b0000);
    checks++;
    if (rx_data_val !== 1'b1 || rx_data !== JUNK) begin
      errors++;
      $display("FAIL post_rst: val=%b data=%h want 1/deadbeef",
               rx_data_val, rx_data);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cont_hold();
    test_orphan_cont();
    test_errors();
    test_phy_drop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
